cache_dados_refill: RTL and testbench
=====================================

// Module: cache_dados_refill
// PURPOSE
// - Parametrised direct-mapped L1 data cache for the pipelined RISC-V core, MEM stage.
// - Successor to the fixed 8-line/8-byte read-only data cache: configurable lines and
//   words per line, miss refill from backing memory, write-through stores.
// - Combinational hit path. Stalls the pipeline during refill or store.
// - Sits between the MEM stage (MemRead/MemWrite) and a single-port word memory bus.
// PARAMETERS
// - LINHAS    8   number of lines (power of 2, >=2); IDX_W = clog2(LINHAS)
// - PALAVRAS  2   32-bit words per line (power of 2, >=1); WOFF_W = clog2(PALAVRAS)
// - ADDR_W    32  byte address width
// - Derived: OFF_W = WOFF_W+2; TAG_W = ADDR_W-IDX_W-OFF_W
//   (defaults: index [5:3], word [2], tag [31:6])
// PORTS
// - clock              in   1       clock, rising edge
// - reset              in   1       reset, asynchronous, active-high
// - MemRead            in   1       load request from MEM stage
// - MemWrite           in   1       store request from MEM stage (word store only)
// - endereco           in   ADDR_W  byte address; bits [1:0] ignored
// - dado_escrita       in   32      store data
// - dado_lido          out  32      load data, valid when MemRead && !stall_cache_dados
// - stall_cache_dados  out  1       freeze pipeline
// - mem_req            out  1       memory request, held until mem_ack
// - mem_we             out  1       1 = write, 0 = read; valid with mem_req
// - mem_addr           out  ADDR_W  word-aligned memory address
// - mem_wdata          out  32      memory write data
// - mem_ack            in   1       one-cycle completion; mem_rdata valid in same cycle
// - mem_rdata          in   32      memory read data
// BEHAVIOUR
// - Reset (async):
//   - all valid bits 0; FSM IDLE; word counter 0.
//   - mem_req, mem_we, mem_addr, mem_wdata all 0. Tag/data arrays not reset.
//   - Reset mid-refill or mid-store aborts the transaction: mem_req falls immediately,
//     and the partially filled line stays invalid.
// - Hit: valid[idx] && tag[idx]==tag(endereco).
//   - dado_lido = word[endereco[OFF_W-1:2]] of line idx when hit, else 32'h0.
// - stall_cache_dados = (state!=IDLE) || (MemRead && !hit) || MemWrite-start in IDLE.
//   Combinational in IDLE.
// - FSM states IDLE, REFILL, STORE:
//   - IDLE + MemWrite -> STORE.
//     - Latch addr/data; mem_req=1, mem_we=1 from the next cycle.
//     - MemWrite has priority when MemRead is also high.
//   - IDLE + MemRead && !hit -> REFILL.
//     - Latch block base (addr & ~(2^OFF_W-1)); word counter = 0.
//   - IDLE otherwise: stay; mem_req=0.
//   - REFILL:
//     - mem_req=1, mem_we=0, mem_addr = base + 4*cnt.
//     - On mem_ack: data[idx][cnt] <= mem_rdata; cnt++.
//     - On ack of the last word (cnt==PALAVRAS-1): valid[idx]<=1, tag[idx]<=tag;
//       -> IDLE, mem_req=0.
//     - The next cycle hits, so stall drops combinationally.
//   - STORE:
//     - Write-through, no-write-allocate.
//     - On mem_ack: if the latched address hits, update that word in the line;
//       a miss leaves the cache untouched.
//     - Then -> IDLE. stall stays 1 through the ack cycle and falls the cycle after.
// - mem_ack while mem_req=0 is ignored. mem_addr/mem_wdata stable while mem_req=1.
// - Refill replaces the line unconditionally: direct-mapped, no dirty state.
// - endereco changes during a stall do not affect an in-flight transaction.
//   The pipeline holds endereco stable anyway.
// - Minimum miss latency: PALAVRAS+1 cycles with zero-wait ack.
// STRUCTURE
// - Shared package cache_pkg:
//   - state enum (IDLE=2'd0, REFILL=2'd1, STORE=2'd2).
//   - clog2 helper function.
//   - tag/index/offset extraction functions parameterised by LINHAS/PALAVRAS.
// - Sub-module cache_dados_array:
//   - valid/tag/data storage.
//   - async read port; single write port with word enable; valid clear on reset.
// - The top level holds the FSM, the counter, the latched transaction registers and the
//   bus outputs.
// TESTING
// - Reset, then MemRead @0x40 (defaults):
//   - stall=1; mem_req reads 0x40 then 0x44.
//   - Acks 0x11111111/0x22222222 -> next cycle hit.
//   - dado_lido=0x11111111; @0x44 -> 0x22222222 with stall=0.
// - Conflict: after filling 0x40, MemRead @0x80 (same idx 0, different tag):
//   - refill at 0x80/0x84.
//   - A re-read of 0x40 then misses and refills again.
// - Store hit: MemWrite @0x44 data 0xDEADBEEF:
//   - mem_req=1, we=1, addr 0x44, wdata 0xDEADBEEF.
//   - Ack after 3 wait cycles -> stall held 4 cycles.
//   - Subsequent read @0x44 = 0xDEADBEEF with no refill.
// - Store miss: MemWrite @0x100 -> memory write issued.
//   - The following MemRead @0x100 still misses (no allocate).
// - Reset asserted during REFILL after the first ack:
//   - mem_req drops in the same cycle.
//   - A MemRead of the same address afterwards restarts the refill at word 0.
// - Params LINHAS=16, PALAVRAS=4: read @0x3C -> 4 requests 0x30..0x3C.
//   - Line idx 3 valid; dado_lido = 4th acked word.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
// Field helpers take the geometry as arguments so every instance can share them.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      STORE  = 2'd2
   } cache_state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 32'd0;
      while ((32'd1 << r) < n) begin
         r = r + 32'd1;
      end
      return r;
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                            input int unsigned linhas,
                                            input int unsigned palavras);
      return addr >> (clog2(linhas) + clog2(palavras) + 32'd2);
   endfunction

   function automatic logic [63:0] addr_idx(input logic [63:0] addr,
                                            input int unsigned linhas,
                                            input int unsigned palavras);
      return (addr >> (clog2(palavras) + 32'd2)) & (64'(linhas) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_word(input logic [63:0] addr,
                                             input int unsigned palavras);
      return (addr >> 2) & (64'(palavras) - 64'd1);
   endfunction

endpackage

// File: rtl/cache_dados_array.sv
// Valid/tag/data storage: asynchronous read, one word-enabled write port.
// Only the valid bits are reset; tags and data are qualified by them.
module cache_dados_array #(
   parameter int unsigned LINHAS   = 8,
   parameter int unsigned PALAVRAS = 2,
   parameter int unsigned TAG_W    = 26,
   parameter int unsigned IDX_W    = 3,
   parameter int unsigned CNT_W    = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDX_W-1:0] idx,
   input  logic [CNT_W-1:0] rd_word,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_word,
   input  logic [31:0]      wr_data,
   input  logic             set_valid,
   input  logic [TAG_W-1:0] set_tag,
   input  logic             clr_valid
);

   logic [LINHAS-1:0] valid_r;
   logic [TAG_W-1:0]  tag_r  [LINHAS];
   logic [31:0]       data_r [LINHAS][PALAVRAS];

   assign rd_valid = valid_r[idx];
   assign rd_tag   = tag_r[idx];
   assign rd_data  = data_r[idx][rd_word];

   // valid bits: cleared on reset and at refill start, set when the line completes
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_r <= {LINHAS{1'b0}};
      end else if (set_valid) begin
         valid_r[idx] <= 1'b1;
      end else if (clr_valid) begin
         valid_r[idx] <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   // tag and data storage
   always_ff @(posedge clock) begin
      if (wr_en) begin
         data_r[idx][wr_word] <= wr_data;
      end
      if (set_valid) begin
         tag_r[idx] <= set_tag;
      end
   end

endmodule

// File: rtl/cache_dados_refill.sv
// Direct-mapped write-through L1 data cache with miss refill from a word bus.
// Hit path is combinational; the pipeline is stalled during refill or store.
module cache_dados_refill
   import cache_pkg::*;
#(
   parameter int unsigned LINHAS   = 8,
   parameter int unsigned PALAVRAS = 2,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] endereco,
   input  logic [31:0]       dado_escrita,
   output logic [31:0]       dado_lido,
   output logic              stall_cache_dados,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned IDX_W  = clog2(LINHAS);
   localparam int unsigned WOFF_W = clog2(PALAVRAS);
   localparam int unsigned OFF_W  = WOFF_W + 32'd2;
   localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int unsigned CNT_W  = (WOFF_W > 32'd0) ? WOFF_W : 32'd1;

   cache_state_t      state_r, state_n;
   logic [CNT_W-1:0]  cnt_r, cnt_n;
   logic              done_r, done_n;
   logic              req_r, req_n;
   logic              we_r, we_n;
   logic [ADDR_W-1:0] addr_r, addr_n;
   logic [31:0]       wdata_r, wdata_n;

   logic [ADDR_W-1:0] lk_addr_s, base_s, aligned_s;
   logic [IDX_W-1:0]  idx_s;
   logic [TAG_W-1:0]  tag_s, rd_tag_s;
   logic [CNT_W-1:0]  rd_word_s, wr_word_s;
   logic [31:0]       rd_data_s, wr_data_s;
   logic              rd_valid_s, hit_s, wr_en_s, set_valid_s, clr_valid_s, stall_s;

   // Outside IDLE the lookup follows the latched bus address, not the pipeline.
   assign lk_addr_s = (state_r == IDLE) ? endereco : addr_r;
   assign idx_s     = IDX_W'(addr_idx(64'(lk_addr_s), LINHAS, PALAVRAS));
   assign tag_s     = TAG_W'(addr_tag(64'(lk_addr_s), LINHAS, PALAVRAS));
   assign rd_word_s = CNT_W'(addr_word(64'(lk_addr_s), PALAVRAS));
   assign hit_s     = rd_valid_s && (rd_tag_s == tag_s);
   assign aligned_s = {endereco[ADDR_W-1:2], 2'b00};
   assign base_s    = endereco & ~(ADDR_W'((64'd1 << OFF_W) - 64'd1));
   assign wr_word_s = (state_r == REFILL) ? cnt_r : rd_word_s;
   assign wr_data_s = (state_r == REFILL) ? mem_rdata : wdata_r;

   cache_dados_array #(
      .LINHAS(LINHAS), .PALAVRAS(PALAVRAS), .TAG_W(TAG_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) u_array (
      .clock(clock), .reset(reset), .idx(idx_s), .rd_word(rd_word_s),
      .rd_valid(rd_valid_s), .rd_tag(rd_tag_s), .rd_data(rd_data_s),
      .wr_en(wr_en_s), .wr_word(wr_word_s), .wr_data(wr_data_s),
      .set_valid(set_valid_s), .set_tag(tag_s), .clr_valid(clr_valid_s)
   );

   // next-state, bus register updates and array write controls
   always_comb begin
      state_n     = state_r;
      cnt_n       = cnt_r;
      done_n      = 1'b0;
      req_n       = req_r;
      we_n        = we_r;
      addr_n      = addr_r;
      wdata_n     = wdata_r;
      wr_en_s     = 1'b0;
      set_valid_s = 1'b0;
      clr_valid_s = 1'b0;
      stall_s     = 1'b0;
      case (state_r)
         IDLE: begin
            // done_r keeps a still-held MemWrite from reissuing the finished store
            if (MemWrite && !done_r) begin
               state_n = STORE;
               req_n   = 1'b1;
               we_n    = 1'b1;
               addr_n  = aligned_s;
               wdata_n = dado_escrita;
               stall_s = 1'b1;
            end else if (MemRead && !MemWrite && !hit_s) begin
               state_n     = REFILL;
               cnt_n       = {CNT_W{1'b0}};
               req_n       = 1'b1;
               we_n        = 1'b0;
               addr_n      = base_s;
               clr_valid_s = 1'b1;
               stall_s     = 1'b1;
            end else begin
               req_n = 1'b0;
               we_n  = 1'b0;
            end
         end
         REFILL: begin
            stall_s = 1'b1;
            if (mem_ack) begin
               wr_en_s = 1'b1;
               if (cnt_r == CNT_W'(PALAVRAS - 32'd1)) begin
                  set_valid_s = 1'b1;
                  state_n     = IDLE;
                  req_n       = 1'b0;
                  cnt_n       = {CNT_W{1'b0}};
               end else begin
                  cnt_n  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  addr_n = addr_r + ADDR_W'(32'd4);
               end
            end else begin
               state_n = REFILL;
            end
         end
         STORE: begin
            stall_s = 1'b1;
            if (mem_ack) begin
               wr_en_s = hit_s;
               state_n = IDLE;
               req_n   = 1'b0;
               we_n    = 1'b0;
               done_n  = 1'b1;
            end else begin
               state_n = STORE;
            end
         end
         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
            we_n    = 1'b0;
         end
      endcase
   end

   // state and bus registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         done_r  <= 1'b0;
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= 32'h0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         done_r  <= done_n;
         req_r   <= req_n;
         we_r    <= we_n;
         addr_r  <= addr_n;
         wdata_r <= wdata_n;
      end
   end

   assign mem_req           = req_r;
   assign mem_we            = we_r;
   assign mem_addr          = addr_r;
   assign mem_wdata         = wdata_r;
   assign stall_cache_dados = stall_s;
   assign dado_lido         = hit_s ? rd_data_s : 32'h0;

endmodule

// File: tb/tb_cache_dados_refill.sv
// Randomised bench for cache_dados_refill against a line-level cache/memory model.
module tb_cache_dados_refill;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rd = 1'b0, wr = 1'b0, ack = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0, rdata = 32'h0;
   logic [31:0] dado, maddr, mwdata;
   logic        stall, req, we;

   logic        b_rd = 1'b0, b_wr = 1'b0, b_ack = 1'b0;
   logic [31:0] b_addr = 32'h0, b_wdata = 32'h0, b_rdata = 32'h0;
   logic [31:0] b_dado, b_maddr, b_mwdata;
   logic        b_stall, b_req, b_we;

   int total = 0;
   int bad   = 0;

   // model: memory words plus the 8x2-word cache contents
   logic [31:0] mem_m [logic [31:0]];
   bit          mv [8];
   logic [31:0] mt [8];
   logic [31:0] md [8][2];

   always #5 clock = ~clock;

   cache_dados_refill dut (
      .clock(clock), .reset(reset), .MemRead(rd), .MemWrite(wr), .endereco(addr),
      .dado_escrita(wdata), .dado_lido(dado), .stall_cache_dados(stall),
      .mem_req(req), .mem_we(we), .mem_addr(maddr), .mem_wdata(mwdata),
      .mem_ack(ack), .mem_rdata(rdata)
   );

   cache_dados_refill #(.LINHAS(16), .PALAVRAS(4), .ADDR_W(32)) dut_b (
      .clock(clock), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr), .endereco(b_addr),
      .dado_escrita(b_wdata), .dado_lido(b_dado), .stall_cache_dados(b_stall),
      .mem_req(b_req), .mem_we(b_we), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
      .mem_ack(b_ack), .mem_rdata(b_rdata)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a, input int maxw);
      int          idx, w0, k;
      logic [31:0] tg, base, v;
      idx  = int'((a >> 3) & 32'd7);
      w0   = int'((a >> 2) & 32'd1);
      tg   = a >> 6;
      base = a & 32'hFFFF_FFF8;
      v    = 32'h0;
      rd   = 1'b1;
      addr = a;
      @(negedge clock);
      if (mv[idx] && mt[idx] == tg) begin
         check_eq("ld_hit_stall", stall, 0);
         check_eq("ld_hit_noreq", req, 0);
         check_eq("ld_hit_data", dado, md[idx][w0]);
      end else begin
         check_eq("ld_miss_stall", stall, 1);
         mv[idx] = 0;
         next_cycle();
         for (int w = 0; w < 2; w++) begin
            k = int'($urandom_range(maxw, 0));
            for (int c = 0; c <= k; c++) begin
               if (c == k) begin
                  v     = memrd(base + 32'(4 * w));
                  ack   = 1'b1;
                  rdata = v;
               end
               @(negedge clock);
               check_eq("rf_req", req, 1);
               check_eq("rf_we", we, 0);
               check_eq("rf_addr", maddr, base + 32'(4 * w));
               check_eq("rf_stall", stall, 1);
               next_cycle();
            end
            ack      = 1'b0;
            rdata    = $urandom;
            md[idx][w] = v;
         end
         mv[idx] = 1;
         mt[idx] = tg;
         @(negedge clock);
         check_eq("rf_done_stall", stall, 0);
         check_eq("rf_done_req", req, 0);
         check_eq("rf_done_data", dado, md[idx][w0]);
      end
      next_cycle();
      rd = 1'b0;
   endtask

   // k = request cycles without ack before the ack cycle
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int k);
      int          idx, w0, nst;
      logic [31:0] al;
      idx   = int'((a >> 3) & 32'd7);
      w0    = int'((a >> 2) & 32'd1);
      al    = a & 32'hFFFF_FFFC;
      nst   = 0;
      wr    = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clock);
      check_eq("st_start_stall", stall, 1);
      nst += int'(stall);
      next_cycle();
      addr  = $urandom;
      wdata = $urandom;
      for (int c = 0; c <= k; c++) begin
         if (c == k) ack = 1'b1;
         @(negedge clock);
         check_eq("st_req", req, 1);
         check_eq("st_we", we, 1);
         check_eq("st_addr", maddr, al);
         check_eq("st_wdata", mwdata, d);
         nst += int'(stall);
         next_cycle();
      end
      ack = 1'b0;
      @(negedge clock);
      check_eq("st_done_req", req, 0);
      nst += int'(stall);
      check_eq("st_stall_cycles", nst, k + 2);
      mem_m[al] = d;
      if (mv[idx] && mt[idx] == (al >> 6)) md[idx][w0] = d;
      next_cycle();
      wr = 1'b0;
   endtask

   task automatic idle_ack();
      ack = 1'b1;
      @(negedge clock);
      check_eq("idle_ack_req", req, 0);
      check_eq("idle_ack_stall", stall, 0);
      next_cycle();
      ack = 1'b0;
   endtask

   initial begin
      logic [31:0] ra, v3;
      int          op;
      for (int i = 0; i < 8; i++) mv[i] = 0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clock);
      check_eq("rst_req", req, 0);
      check_eq("rst_we", we, 0);
      check_eq("rst_addr", maddr, 0);
      check_eq("rst_wdata", mwdata, 0);
      check_eq("rst_stall", stall, 0);
      check_eq("rst_dado", dado, 0);
      next_cycle();

      mem_m[32'h40] = 32'h1111_1111;
      mem_m[32'h44] = 32'h2222_2222;
      do_load(32'h40, 0);
      do_load(32'h44, 0);
      check_eq("dir_44", md[0][1], 32'h2222_2222);
      do_load(32'h80, 1);
      do_load(32'h40, 1);
      do_store(32'h44, 32'hDEAD_BEEF, 2);
      do_load(32'h44, 0);
      do_store(32'h100, 32'hCAFE_0100, 1);
      do_load(32'h100, 1);

      // reset during refill, after the first ack
      rd   = 1'b1;
      addr = 32'h48;
      next_cycle();
      ack   = 1'b1;
      rdata = 32'h5555_AAAA;
      next_cycle();
      ack = 1'b0;
      @(negedge clock);
      check_eq("mid_req", req, 1);
      check_eq("mid_addr", maddr, 32'h4C);
      #1 reset = 1'b1;
      #1;
      check_eq("mid_rst_req", req, 0);
      check_eq("mid_rst_addr", maddr, 0);
      next_cycle();
      reset = 1'b0;
      rd    = 1'b0;
      for (int i = 0; i < 8; i++) mv[i] = 0;
      next_cycle();
      do_load(32'h48, 0);

      for (int n = 0; n < 150; n++) begin
         ra = ($urandom_range(3, 0) << 6) | ($urandom_range(7, 0) << 3) |
              ($urandom_range(1, 0) << 2) | $urandom_range(3, 0);
         op = int'($urandom_range(9, 0));
         if (op <= 5) do_load(ra, 2);
         else if (op <= 8) do_store(ra, $urandom, int'($urandom_range(3, 0)));
         else idle_ack();
      end

      // 16 lines x 4 words instance
      b_rd   = 1'b1;
      b_addr = 32'h3C;
      v3     = 32'h0;
      @(negedge clock);
      check_eq("b_miss_stall", b_stall, 1);
      next_cycle();
      for (int w = 0; w < 4; w++) begin
         b_ack   = 1'b1;
         b_rdata = 32'hB000_0000 + 32'(w);
         v3      = b_rdata;
         @(negedge clock);
         check_eq("b_req", b_req, 1);
         check_eq("b_addr", b_maddr, 32'h30 + 32'(4 * w));
         next_cycle();
      end
      b_ack = 1'b0;
      @(negedge clock);
      check_eq("b_done_stall", b_stall, 0);
      check_eq("b_data", b_dado, v3);
      next_cycle();
      b_addr = 32'h34;
      @(negedge clock);
      check_eq("b_hit34_stall", b_stall, 0);
      check_eq("b_hit34", b_dado, 32'hB000_0001);
      next_cycle();
      b_rd = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
